dmem_responder: RTL and testbench

//  Data-memory responder on the core's load/store bus: the target end of the

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target on the core's load/store bus.
// Handles one request at a time: byte-lane stores (SB/SH/SW) and
// sign/zero-extended loads (LB/LH/LW/LBU/LHU), with a registered response.
// Optional access-fault detection is compiled in by defining DMEM_ERR_EN.
//
// state  | meaning
// IDLE   | waiting for a request; o_req_ready=1 (except the cycle right after reset)
// WAIT   | request latched; counts down WAIT_CYCLES, commits on the edge into RESP
// RESP   | response held stable until o_rsp_valid & i_rsp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [2:0]    r_funct3;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [1:0]    w_size;
  logic [1:0]    w_lane;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_commit;

  assign w_idx    = r_addr[AW+1:2];
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef DMEM_ERR_EN
  // Fault on reserved size, misaligned half/word, or a word index past the array.
  always_comb begin
    w_size = r_funct3[1:0];
    w_lane = r_addr[1:0];
    w_err  = (w_size == 2'b11) ||
             ((w_size == 2'b01) && r_addr[0]) ||
             ((w_size == 2'b10) && (r_addr[1:0] != 2'b00)) ||
             ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
  end
`else
  // Upper address bits simply wrap; they carry no information here.
  logic w_unused_addr;
  assign w_unused_addr = ^r_addr[31:AW+2];

  // No faults: size 11 behaves as a word and low address bits are forced aligned.
  always_comb begin
    w_size = (r_funct3[1:0] == 2'b11) ? 2'b10 : r_funct3[1:0];
    w_lane = r_addr[1:0];
    if (w_size == 2'b01) w_lane[0] = 1'b0;
    if (w_size == 2'b10) w_lane = 2'b00;
    w_err = 1'b0;
  end
`endif

  // Store byte enables; data is replicated so every candidate lane sees it.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  // Load lane select and extension; funct3[2] only matters for B/H.
  always_comb begin
    w_word = r_mem[w_idx];
    case (w_lane)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    case (w_size)
      2'b00:   w_load = r_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Storage has no reset; a store lands on the commit edge unless reset or a fault blocks it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_commit && r_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Request/response sequencing with registered handshake outputs.
  // WAIT is always visited once so the commit uses a fully latched request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_funct3    <= 3'b000;
      r_wdata     <= 32'h0;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'h0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_req_ready <= 1'b1;
          if (i_req_valid && o_req_ready) begin
            r_we        <= i_req_we;
            r_addr      <= i_req_addr;
            r_funct3    <= i_req_funct3;
            r_wdata     <= i_req_wdata;
            r_cnt       <= 4'(WAIT_CYCLES);
            o_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= (r_we || w_err) ? 32'h0 : w_load;
            o_rsp_err   <= w_err;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: vector table driven through a request task,
// expected responses queued at issue and popped when the response appears.
module tb_dmem_responder;

  localparam int WAIT_CYCLES = 1;
  localparam int DEPTH       = 1024;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_funct3(req_funct3),
    .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  rsp_t sb_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic void add(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] wd, input logic [31:0] d, input logic e);
    vec_t v;
    v.we = we; v.addr = addr; v.f3 = f3; v.wd = wd; v.exp_d = d; v.exp_e = e;
    vecs.push_back(v);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  // One full transaction; hold>0 keeps rsp_ready low for that many cycles of RESP.
  task automatic xfer(input vec_t v, input int hold);
    rsp_t        exp;
    int          k;
    logic [31:0] held;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_addr   = v.addr;
    req_funct3 = v.f3;
    req_wdata  = v.wd;
    rsp_ready  = (hold == 0);
    exp.d = v.exp_d;
    exp.e = v.exp_e;
    sb_q.push_back(exp);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      expire("accept");
      req_valid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin
      chk("ready_low_in_wait", 32'(req_ready), 32'd0);
      @(negedge clk);
      k++;
    end
    if (!rsp_valid) begin
      expire("response");
      void'(sb_q.pop_front());
      return;
    end
    chk("latency", 32'(k), 32'(WAIT_CYCLES + 2));
    exp = sb_q.pop_front();
    chk("rsp_rdata", rsp_rdata, exp.d);
    chk("rsp_err", 32'(rsp_err), 32'(exp.e));
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, held);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   k;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_funct3 = 3'b000; req_wdata = 32'h0; rsp_ready = 1'b0;

    // we, addr, funct3, wdata, expected rdata, expected err
    add(1'b1, 32'h100, 3'b010, 32'h12345678, 32'h00000000, 1'b0);
    add(1'b0, 32'h100, 3'b010, 32'h0,        32'h12345678, 1'b0);
    add(1'b1, 32'h101, 3'b000, 32'hCCCCCCAB, 32'h00000000, 1'b0);
    add(1'b0, 32'h100, 3'b010, 32'h0,        32'h1234AB78, 1'b0);
    add(1'b0, 32'h101, 3'b000, 32'h0,        32'hFFFFFFAB, 1'b0);
    add(1'b0, 32'h101, 3'b100, 32'h0,        32'h000000AB, 1'b0);
    add(1'b1, 32'h102, 3'b001, 32'h77778001, 32'h00000000, 1'b0);
    add(1'b0, 32'h102, 3'b001, 32'h0,        32'hFFFF8001, 1'b0);
    add(1'b0, 32'h102, 3'b101, 32'h0,        32'h00008001, 1'b0);
    add(1'b0, 32'h100, 3'b010, 32'h0,        32'h8001AB78, 1'b0);
    add(1'b0, 32'h100, 3'b000, 32'h0,        32'h00000078, 1'b0);
    add(1'b0, 32'h100, 3'b001, 32'h0,        32'hFFFFAB78, 1'b0);
    add(1'b0, 32'h103, 3'b100, 32'h0,        32'h00000080, 1'b0);
    add(1'b0, 32'h103, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0);
    add(1'b1, 32'h103, 3'b000, 32'h00000011, 32'h00000000, 1'b0);
    add(1'b0, 32'h100, 3'b010, 32'h0,        32'h1101AB78, 1'b0);
    add(1'b1, 32'h104, 3'b010, 32'hCAFEF00D, 32'h00000000, 1'b0);
    add(1'b0, 32'h106, 3'b101, 32'h0,        32'h0000CAFE, 1'b0);
    add(1'b0, 32'h104, 3'b001, 32'h0,        32'hFFFFF00D, 1'b0);
    add(1'b0, 32'h104, 3'b110, 32'h0,        32'hCAFEF00D, 1'b0);
    add(1'b0, 32'h100, 3'b010, 32'h0,        32'h1101AB78, 1'b0);
    add(1'b0, 32'h100 + 32'(4 * DEPTH), 3'b010, 32'h0,
        ERR_EN ? 32'h0 : 32'h1101AB78, ERR_EN);
    add(1'b1, 32'h200, 3'b010, 32'h0BADF00D, 32'h00000000, 1'b0);
    add(1'b0, 32'h200, 3'b010, 32'h0,        32'h0BADF00D, 1'b0);

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;
    @(negedge clk) chk("ready_after_reset", 32'(req_ready), 32'd1);

    foreach (vecs[i]) xfer(vecs[i], 0);

    // Response held off for five cycles.
    v.we = 1'b0; v.addr = 32'h104; v.f3 = 3'b010; v.wd = 32'h0;
    v.exp_d = 32'hCAFEF00D; v.exp_e = 1'b0;
    xfer(v, 5);

    // Reset during WAIT of a store: the store must never land.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200;
    req_funct3 = 3'b010; req_wdata = 32'hDEADBEEF; rsp_ready = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) expire("abort_accept");
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 check_reset_outputs("abort");
    end
    @(negedge clk) rst = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk) chk("ready_after_abort", 32'(req_ready), 32'd1);
    v.we = 1'b0; v.addr = 32'h200; v.f3 = 3'b010; v.wd = 32'h0;
    v.exp_d = 32'h0BADF00D; v.exp_e = 1'b0;
    xfer(v, 0);

    // Misaligned word store: faults when checking is built in, else aligns down.
    v.we = 1'b1; v.addr = 32'h202; v.f3 = 3'b010; v.wd = 32'h00000001;
    v.exp_d = 32'h0; v.exp_e = ERR_EN;
    xfer(v, 0);
    v.we = 1'b0; v.addr = 32'h200; v.f3 = 3'b010; v.wd = 32'h0;
    v.exp_d = ERR_EN ? 32'h0BADF00D : 32'h00000001; v.exp_e = 1'b0;
    xfer(v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
